spi_config_rx: RTL and testbench
================================

// Module: spi_config_rx
// PURPOSE
// Write-only serial configuration receiver for the synthesizer. Shifts in one
// 61-bit MSB-first frame on mosi, framed by active-low nss, and sampled on the
// system clock (no separate serial clock). Distributes the frame to the ADSR,
// oscillator and filter parameter registers. Pulses trig when a complete frame
// has been committed.
// PARAMETERS
// none -- frame length (61) and field layout are fixed.
// PORTS
// clk        in   1   system clock; all logic on rising edge
// rst        in   1   reset, synchronous, active-high
// mosi       in   1   serial data, sampled on clk rising edge while nss=0
// nss        in   1   frame select, active-low
// adsr_ai    out  8   ADSR attack increment
// adsr_di    out  8   ADSR decay increment
// adsr_s     out  8   ADSR sustain level
// adsr_ri    out  8   ADSR release increment
// osc_count  out  12  oscillator period count
// filter_a   out  8   filter coefficient A
// filter_b   out  8   filter coefficient B
// progn      out  1   program flag, active-low
// trig       out  1   one-cycle pulse: new configuration committed
// BEHAVIOUR
// - One clock domain; reset is synchronous and active-high. mosi and nss are
//   treated as synchronous to clk; no input synchronizers.
// - Reset values: adsr_*, osc_count, filter_* = 0; progn = 1; trig = 0.
//   Reset also clears the shift register, clears the bit counter and
//   de-arms the receiver.
// - Arming: the receiver arms when nss is sampled high. A frame starts on the
//   first edge with nss=0 while armed. If nss is already low when reset is
//   released, bits are ignored until nss has been high for at least one
//   edge.
// - During a frame, each rising edge with nss=0 shifts mosi into the LSB of a
//   61-bit shift register (MSB first). It also increments a bit counter that
//   saturates at 62.
// - End of frame = first edge sampling nss=1 after a frame.
//   - Counter == 61: registers are loaded from sr[60:0] on that edge, and trig
//     is 1 for exactly that following cycle.
//   - Counter != 61 (short or long frame): the frame is discarded, registers
//     are unchanged and trig stays 0.
//   - The counter clears at the end of every frame.
// - Frame layout, sr[60:0], first bit received = bit 60:
//   [60:53] adsr_ai  [52:45] adsr_di  [44:37] adsr_s  [36:29] adsr_ri
//   [28:17] osc_count  [16:9] filter_a  [8:1] filter_b  [0] progn
// - Outputs are registered and hold their values between frames. They never
//   show partial frames.
// - Back-to-back frames with a single nss-high cycle between them are
//   supported.
// - Reset asserted mid-frame: the frame is aborted, outputs go to reset
//   values, and no trig is produced.
// TESTING
// - Reset, then nss=1 idle -> all fields 0, progn=1, trig=0.
// - 61-bit frame 0x1123456789ABCDEF -> adsr_ai=0x89, adsr_di=0x1A,
//   adsr_s=0x2B, adsr_ri=0x3C, osc_count=0x4D5, filter_a=0xE6,
//   filter_b=0xF7, progn=1; trig high for 1 cycle.
// - 60-bit frame and 62-bit frame -> previous values kept, no trig.
// - Two consecutive valid frames, 1-cycle nss gap -> second frame's values
//   applied, two trig pulses.
// - rst pulse after bit 30 of a frame -> reset values, no trig; the next full
//   frame loads correctly.
// - nss held low through reset release, then 61 bits -> ignored until nss
//   toggles high; a subsequent valid frame loads.

Source files
------------

// File: rtl/spi_config_rx.sv
// Write-only serial configuration receiver: shifts in a 61-bit MSB-first frame
// framed by active-low nss, sampled on clk, and commits it to the parameter registers.
module spi_config_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        mosi,
  input  logic        nss,
  output logic [7:0]  adsr_ai,
  output logic [7:0]  adsr_di,
  output logic [7:0]  adsr_s,
  output logic [7:0]  adsr_ri,
  output logic [11:0] osc_count,
  output logic [7:0]  filter_a,
  output logic [7:0]  filter_b,
  output logic        progn,
  output logic        trig
);

  localparam logic [5:0]  FRAME_BITS = 6'd61;
  localparam logic [5:0]  CNT_SAT    = 6'd62;
  localparam logic [60:0] CFG_RESET  = 61'h1;

  logic        armed_q, armed_d;
  logic [60:0] sr_q, sr_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [60:0] cfg_q, cfg_d;
  logic        trig_q, trig_d;

  // A non-zero counter means a frame is in progress; nss high then closes it.
  always_comb begin
    armed_d = armed_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    trig_d  = 1'b0;
    if (nss) begin
      armed_d = 1'b1;
      if (cnt_q != 6'd0) begin
        if (cnt_q == FRAME_BITS) begin
          cfg_d  = sr_q;
          trig_d = 1'b1;
        end
        cnt_d = 6'd0;
      end
    end else if (armed_q) begin
      sr_d = {sr_q[59:0], mosi};
      if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b0;
      sr_q    <= '0;
      cnt_q   <= '0;
      cfg_q   <= CFG_RESET;
      trig_q  <= 1'b0;
    end else begin
      armed_q <= armed_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      trig_q  <= trig_d;
    end
  end

  assign adsr_ai   = cfg_q[60:53];
  assign adsr_di   = cfg_q[52:45];
  assign adsr_s    = cfg_q[44:37];
  assign adsr_ri   = cfg_q[36:29];
  assign osc_count = cfg_q[28:17];
  assign filter_a  = cfg_q[16:9];
  assign filter_b  = cfg_q[8:1];
  assign progn     = cfg_q[0];
  assign trig      = trig_q;

endmodule

// File: tb/tb_spi_config_rx.sv
// Bench for spi_config_rx: directed and random frames checked every cycle
// against a bit-queue reference model of the frame rules.
module tb_spi_config_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        mosi;
  logic        nss;
  logic [7:0]  adsr_ai, adsr_di, adsr_s, adsr_ri, filter_a, filter_b;
  logic [11:0] osc_count;
  logic        progn, trig;

  int checkCount = 0;
  int errorCount = 0;
  int trigSeen   = 0;

  bit          modelArmed;
  bit          modelBits[$];
  logic [7:0]  expAi, expDi, expS, expRi, expFa, expFb;
  logic [11:0] expOsc;
  logic        expProgn, expTrig;

  spi_config_rx dut (
    .clk(clk), .rst(rst), .mosi(mosi), .nss(nss),
    .adsr_ai(adsr_ai), .adsr_di(adsr_di), .adsr_s(adsr_s), .adsr_ri(adsr_ri),
    .osc_count(osc_count), .filter_a(filter_a), .filter_b(filter_b),
    .progn(progn), .trig(trig)
  );

  always #5 clk = ~clk;

  function automatic void setExpected(input logic [63:0] v);
    expAi    = 8'((v >> 53) & 64'hFF);
    expDi    = 8'((v >> 45) & 64'hFF);
    expS     = 8'((v >> 37) & 64'hFF);
    expRi    = 8'((v >> 29) & 64'hFF);
    expOsc   = 12'((v >> 17) & 64'hFFF);
    expFa    = 8'((v >> 9) & 64'hFF);
    expFb    = 8'((v >> 1) & 64'hFF);
    expProgn = v[0];
  endfunction

  // Reference: collect bits while armed and nss low; a frame counts only if exactly 61 bits arrived.
  function automatic void updateModel(input logic r, input logic n, input logic m);
    logic [63:0] v;
    expTrig = 1'b0;
    if (r) begin
      modelArmed = 1'b0;
      modelBits.delete();
      setExpected(64'h1);
    end else if (n) begin
      modelArmed = 1'b1;
      if (modelBits.size() == 61) begin
        v = 64'h0;
        foreach (modelBits[i]) v = (v << 1) | 64'(modelBits[i]);
        setExpected(v);
        expTrig = 1'b1;
      end
      modelBits.delete();
    end else if (modelArmed) begin
      modelBits.push_back(m);
    end
  endfunction

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("trig", 64'(trig), 64'(expTrig));
    checkValue("config",
               64'({adsr_ai, adsr_di, adsr_s, adsr_ri, osc_count, filter_a, filter_b, progn}),
               64'({expAi, expDi, expS, expRi, expOsc, expFa, expFb, expProgn}));
  endtask

  task automatic applyStimulus(input logic r, input logic n, input logic m);
    rst  = r;
    nss  = n;
    mosi = m;
    @(posedge clk);
    updateModel(r, n, m);
    #1;
    if (trig === 1'b1) trigSeen++;
    checkOutput();
  endtask

  task automatic sendFrame(input logic [63:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) applyStimulus(1'b0, 1'b0, v[i]);
    applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    logic [63:0] frame;
    int          len;
    rst = 1'b1; nss = 1'b1; mosi = 1'b0;
    modelArmed = 1'b0;
    setExpected(64'h1);
    expTrig = 1'b0;

    $display("[TB] reset and idle");
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    checkValue("reset_fields", 64'({adsr_ai, adsr_di, adsr_s, adsr_ri, osc_count, filter_a, filter_b}), 64'h0);
    checkValue("reset_progn", 64'(progn), 64'h1);

    $display("[TB] known 61-bit frame");
    trigSeen = 0;
    sendFrame(64'h1123456789ABCDEF, 61);
    checkValue("known_ai", 64'(adsr_ai), 64'h89);
    checkValue("known_di", 64'(adsr_di), 64'h1A);
    checkValue("known_s", 64'(adsr_s), 64'h2B);
    checkValue("known_ri", 64'(adsr_ri), 64'h3C);
    checkValue("known_osc", 64'(osc_count), 64'h4D5);
    checkValue("known_fa", 64'(filter_a), 64'hE6);
    checkValue("known_fb", 64'(filter_b), 64'hF7);
    checkValue("known_progn", 64'(progn), 64'h1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkValue("known_trig_count", 64'(trigSeen), 64'd1);

    $display("[TB] short and long frames");
    trigSeen = 0;
    sendFrame({$urandom(), $urandom()}, 60);
    sendFrame({$urandom(), $urandom()}, 62);
    checkValue("bad_len_keep_ai", 64'(adsr_ai), 64'h89);
    checkValue("bad_len_trig_count", 64'(trigSeen), 64'd0);

    $display("[TB] back-to-back frames");
    trigSeen = 0;
    sendFrame({$urandom(), $urandom()}, 61);
    sendFrame({$urandom(), $urandom()}, 61);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkValue("b2b_trig_count", 64'(trigSeen), 64'd2);

    $display("[TB] reset mid-frame");
    trigSeen = 0;
    frame = {$urandom(), $urandom()};
    for (int i = 60; i > 30; i--) applyStimulus(1'b0, 1'b0, frame[i]);
    applyStimulus(1'b1, 1'b0, frame[30]);
    for (int i = 29; i >= 0; i--) applyStimulus(1'b0, 1'b0, frame[i]);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkValue("midreset_trig_count", 64'(trigSeen), 64'd0);
    sendFrame({$urandom(), $urandom()}, 61);
    checkValue("midreset_reload_trig", 64'(trigSeen), 64'd1);

    $display("[TB] nss low through reset release");
    trigSeen = 0;
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
    frame = {$urandom(), $urandom()};
    for (int i = 60; i >= 0; i--) applyStimulus(1'b0, 1'b0, frame[i]);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkValue("unarmed_trig_count", 64'(trigSeen), 64'd0);
    checkValue("unarmed_progn", 64'(progn), 64'h1);
    sendFrame({$urandom(), $urandom()}, 61);
    checkValue("rearmed_trig_count", 64'(trigSeen), 64'd1);

    $display("[TB] random frames");
    for (int k = 0; k < 30; k++) begin
      len = 59 + int'($urandom_range(0, 4));
      if ($urandom_range(0, 1) == 1) len = 61;
      sendFrame({$urandom(), $urandom()}, len);
      repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
